mux_scan_sequencer: RTL and testbench

//  Drives the select lines of the 4:1 multiplexer (behavioralMultiplexer) through all four addresses

---
 rtl/mux_scan_sequencer_pkg.sv | 19 +
 rtl/mux_scan_sequencer_settle_counter.sv | 39 +++
 rtl/mux_scan_sequencer.sv | 96 +++++++++
 tb/tb_mux_scan_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// State encodings are fixed so they line up with external debug probes.
package mux_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic [1:0] ScanLast = 2'd3;

  // Counter width that can hold 0..settle, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle == 0) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_settle_counter.sv
// Settle-time counter: counts enabled cycles from zero.
// tc_o flags the last settle cycle before a sample.
module mux_scan_sequencer_settle_counter
  import mux_scan_sequencer_pkg::*;
#(
  parameter int unsigned SettleCycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int unsigned CntW = cnt_width(SettleCycles);
  localparam logic [CntW-1:0] Last = CntW'((SettleCycles == 0) ? 0 : SettleCycles - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == Last);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks a 4:1 mux through all four select values, samples each after a settle
// time, and presents the assembled 4-bit word on a valid/ready handshake.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       mux_out,
  output logic       addr0,
  output logic       addr1,
  output logic       busy,
  output logic       word_valid,
  input  logic       word_ready,
  output logic [3:0] word
);

  // With no settle time the SETTLE state is skipped entirely.
  localparam bit Bypass = (SETTLE_CYCLES == 0);

  state_e     state_q;
  logic [1:0] index_q;
  logic [3:0] word_q;
  logic       busy_q;
  logic       valid_q;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       cnt_tc;

  // The count restarts from zero on every entry into SETTLE.
  assign cnt_clear  = (state_q == StIdle) || (state_q == StSample);
  assign cnt_enable = (state_q == StSettle);

  mux_scan_sequencer_settle_counter #(
    .SettleCycles(SETTLE_CYCLES)
  ) u_settle_counter (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clear_i (cnt_clear),
    .enable_i(cnt_enable),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      index_q <= 2'd0;
      word_q  <= 4'b0000;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            index_q <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= Bypass ? StSample : StSettle;
          end
        end
        StSettle: begin
          if (cnt_tc) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          word_q[index_q] <= mux_out;
          if (index_q == ScanLast) begin
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            index_q <= index_q + 2'd1;
            state_q <= Bypass ? StSample : StSettle;
          end
        end
        StDone: begin
          if (word_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Select lines come straight from the index register.
  assign addr0      = index_q[1];
  assign addr1      = index_q[0];
  assign busy       = busy_q;
  assign word_valid = valid_q;
  assign word       = word_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: two sequencers (settle 2 and settle 0), each around a 4:1 mux model.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, start0;
  logic       word_ready, ready0;
  logic [3:0] mux_in, in0;
  logic       mux_out, mux_out0;
  logic       addr0, addr1, busy, word_valid;
  logic       d0_addr0, d0_addr1, d0_busy, d0_valid;
  logic [3:0] word, d0_word;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_q0[$];

  always #5 clk = ~clk;

  // 4:1 mux: select = {addr0, addr1}
  assign mux_out  = mux_in[{addr0, addr1}];
  assign mux_out0 = in0[{d0_addr0, d0_addr1}];

  mux_scan_sequencer #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mux_out(mux_out),
    .addr0(addr0), .addr1(addr1), .busy(busy), .word_valid(word_valid),
    .word_ready(word_ready), .word(word)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .mux_out(mux_out0),
    .addr0(d0_addr0), .addr1(d0_addr1), .busy(d0_busy), .word_valid(d0_valid),
    .word_ready(ready0), .word(d0_word)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input bit which);
    if (which) start0 = 1'b1;
    else start = 1'b1;
    tick();
    start  = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic wait_valid(input bit which, output int n);
    n = 0;
    while (!(which ? d0_valid : word_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL wait_valid timeout: got 0 want 1");
    end
  endtask

  // Monitors: pop and compare on each accepted word.
  always @(negedge clk) begin
    if (word_valid && word_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word: got %b want none (unexpected)", word);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (word !== e) begin
          bad++;
          $display("FAIL word: got %b want %b", word, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (d0_valid && ready0) begin
      total++;
      if (exp_q0.size() == 0) begin
        bad++;
        $display("FAIL word0: got %b want none (unexpected)", d0_word);
      end else begin
        logic [3:0] e;
        e = exp_q0.pop_front();
        if (d0_word !== e) begin
          bad++;
          $display("FAIL word0: got %b want %b", d0_word, e);
        end
      end
    end
  end

  initial begin
    int n;
    int v[3];
    int nv;
    int cyc;

    // Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start      = 1'($urandom);
      start0     = 1'($urandom);
      word_ready = 1'($urandom);
      ready0     = 1'($urandom);
      mux_in     = 4'($urandom);
      in0        = 4'($urandom);
      tick();
      chk("reset_state", {addr0, addr1, busy, word_valid, word}, 8'b0);
    end
    start = 1'b0; start0 = 1'b0; word_ready = 1'b1; ready0 = 1'b1;
    reset_n = 1'b1;
    tick();

    // Basic scan: address sequence and latency
    mux_in = 4'b1011;
    exp_q.push_back(4'b1011);
    start_scan(1'b0);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("addr_seq c%0d", c), {addr0, addr1, word_valid}, {2'(c / 3), 1'b0});
      tick();
    end
    chk("valid_at_12", {word_valid, busy, addr0, addr1, word}, {4'b1111, 4'b1011});
    tick();
    chk("idle_after_accept", {busy, word_valid}, 2'b00);

    // Backpressure
    word_ready = 1'b0;
    exp_q.push_back(4'b1011);
    start_scan(1'b0);
    wait_valid(1'b0, n);
    chk("latency_bp", n, 12);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold", {word_valid, busy, addr0, addr1, word}, {4'b1111, 4'b1011});
    end
    word_ready = 1'b1;
    tick();
    chk("bp_release", {busy, word_valid}, 2'b00);

    // start held high: back-to-back scans every 14 cycles
    mux_in = 4'b0110;
    repeat (3) exp_q.push_back(4'b0110);
    start = 1'b1;
    nv = 0;
    cyc = 0;
    while (cyc < 41) begin
      tick();
      cyc++;
      if (cyc == 5) start = 1'b0;
      if (cyc == 6) start = 1'b1;
      if (word_valid && nv < 3) begin
        v[nv] = cyc;
        nv++;
      end
    end
    start = 1'b0;
    chk("b2b_count", nv, 3);
    chk("b2b_first", v[0], 13);
    chk("b2b_second", v[1], 27);
    chk("b2b_third", v[2], 41);
    tick();
    tick();
    chk("b2b_idle", busy, 1'b0);

    // Reset mid-scan discards the partial word
    mux_in = 4'b1011;
    start_scan(1'b0);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("midscan_reset", {addr0, addr1, busy, word_valid, word}, 8'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    mux_in = 4'b1100;
    exp_q.push_back(4'b1100);
    start_scan(1'b0);
    wait_valid(1'b0, n);
    chk("latency_after_reset", n, 12);
    tick();

    // mux_out glitch during settle is ignored
    mux_in = 4'b1011;
    exp_q.push_back(4'b1010);
    start_scan(1'b0);
    tick();
    mux_in = 4'b1010;
    wait_valid(1'b0, n);
    chk("latency_glitch", n, 11);
    tick();

    // Zero settle time
    in0 = 4'b0101;
    exp_q0.push_back(4'b0101);
    start_scan(1'b1);
    wait_valid(1'b1, n);
    chk("latency_settle0", n, 4);
    tick();
    chk("settle0_idle", {d0_busy, d0_valid}, 2'b00);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("queue0_empty", exp_q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
